data_mem_unit: RTL and testbench
================================

# data_mem_unit

Parametrised data memory for the MIPS datapath with byte/halfword/word access, load sign/zero extension, misalignment detection and a hardware clear sequence after reset. It sits behind the ALU address path and serves the load/store unit through a req/ready handshake with a registered read port, replacing the fixed word-only data memory.

## Interface
- `ADDR_BITS`, default 7: word-index width; depth = 2^ADDR_BITS words of 32 bits.
- `ERR_BITS`, default 8: width of the saturating misalignment counter.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  1  access request; accepted when `req && ready`.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `unsigned_ld`  in  1  1 = zero-extend sub-word load, 0 = sign-extend.
- `address`  in  32  byte address; word index = `address[ADDR_BITS+1:2]`, upper bits ignored (wrap).
- `wdata`  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in CLEAR.
- `rvalid`  out  1  one-cycle pulse: `rdata` is valid.
- `rdata`  out  32  extended load result; holds its value until the next load completes.
- `misalign`  out  1  one-cycle pulse: the accepted access was rejected.
- `err_count`  out  ERR_BITS  saturating count of rejected accesses.

## Operation
- States: CLEAR, IDLE.
- `reset` low: state <- CLEAR, clear index <- 0, `rvalid`=0, `misalign`=0, `rdata`=0, `err_count`=0. Memory contents are not touched during reset.
- CLEAR, with `reset` high: write 0 to word[index], then index+1, one word per cycle. After writing word 2^ADDR_BITS-1, go to IDLE.
  - `req` is ignored in CLEAR. `busy`=1, `ready`=0.
- IDLE: `ready`=1. Every cycle with `req` high is an accepted access; back-to-back accesses run at one per cycle.
- Alignment check:
  - byte: always legal;
  - half: illegal if `address[0]`=1;
  - word: illegal if `address[1:0]`≠0;
  - `size`=11: always illegal.
- Illegal access:
  - no memory write; no `rvalid`;
  - `misalign` pulses next cycle;
  - `err_count` increments, saturating at all-ones.
- Store, little-endian lanes:
  - byte writes lane `address[1:0]` with `wdata[7:0]`;
  - half writes lanes {1,0} when `address[1]`=0, lanes {3,2} when `address[1]`=1, with `wdata[15:0]`;
  - word writes all lanes.
  - Other lanes are unchanged.
- Load: select the same lanes, right-align, then extend per `unsigned_ld` (ignored for word). The result is registered into `rdata`.
- A store followed by a load to the same word in the next cycle returns the new data.

## Timing
- Clear latency: 2^ADDR_BITS cycles after the first cycle with `reset` high. `ready` rises on the following edge; `ready` is first high 2^ADDR_BITS cycles after reset release.
- Store: memory is updated at the accepting edge.
- Load: `rvalid` and `rdata` are set at the accepting edge (accept edge N, data visible cycle N+1).
- `misalign` is set at the accepting edge, the same timing as `rvalid`.
- `reset` low at any time, including mid-CLEAR or with a load in flight:
  - the in-flight `rvalid` is suppressed;
  - the clear sequence restarts from index 0 after release.
- `err_count` at all-ones plus another illegal access: stays all-ones and `misalign` still pulses.

## Test plan
- Reset / clear: ADDR_BITS=7, reset low 2 cycles then high.
  - `busy`=1 for exactly 128 cycles, `ready`=0 throughout.
  - A load of word 5 afterwards returns 0x00000000.
- Byte store / load extension: store word 0x11223344 at 0x10, then byte store 0xF0 at 0x12.
  - Word load at 0x10 returns 0x11F03344.
  - Byte load at 0x12, signed, returns 0xFFFFFFF0; unsigned returns 0x000000F0.
- Halfword: store half 0x8001 at 0x22.
  - Signed half load at 0x22 returns 0xFFFF8001.
  - Unsigned half load at 0x20 returns the original lower half, unchanged.
- Misalignment: word store 0xDEADBEEF at 0x41, then half load at 0x43, then `size`=11.
  - Three `misalign` pulses; `err_count`=3.
  - Word at 0x40 unchanged; no `rvalid`.
- Back-to-back and wrap: word store 0xA5A5A5A5 at 0x200 (wraps to index 0), then a load at 0x0 in the next cycle.
  - `rvalid` on the cycle after the load is accepted, with `rdata`=0xA5A5A5A5.
- Reset mid-clear: pull reset low at clear index 60.
  - Index restarts; `busy` lasts a full 128 cycles after release.
  - A load issued at the cycle `reset` falls produces no `rvalid`.

Source files
------------

// File: rtl/data_mem_unit.sv
// Byte/half/word data memory with load extension, misalignment rejection and a
// post-reset clear sweep that zeroes every word before accepting requests.
module data_mem_unit #(
  parameter int ADDR_BITS = 7,
  parameter int ERR_BITS  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [1:0]          size,
  input  logic                unsigned_ld,
  input  logic [31:0]         address,
  input  logic [31:0]         wdata,
  output logic                ready,
  output logic                busy,
  output logic                rvalid,
  output logic [31:0]         rdata,
  output logic                misalign,
  output logic [ERR_BITS-1:0] err_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                r_state, w_state_next;
  logic [ADDR_BITS-1:0]  r_clr_idx;
  logic [31:0]           r_mem [DEPTH];
  logic                  r_rvalid, r_misalign;
  logic [31:0]           r_rdata;
  logic [ERR_BITS-1:0]   r_err_count;

  logic [ADDR_BITS-1:0]  w_idx;
  logic                  w_legal, w_accept, w_store, w_load, w_reject;
  logic [3:0]            w_be;
  logic [31:0]           w_wlanes, w_rd_word, w_load_data;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_unused_addr;

  // Address bits above the word index wrap around and are intentionally ignored.
  assign w_idx         = address[ADDR_BITS+1:2];
  assign w_unused_addr = ^address[31:ADDR_BITS+2];

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_CLEAR: begin
        busy = 1'b1;
        if (r_clr_idx == {ADDR_BITS{1'b1}}) w_state_next = S_IDLE;
      end
      default: ready = 1'b1;
    endcase
  end

  always_comb begin
    case (size)
      2'b00:   w_legal = 1'b1;
      2'b01:   w_legal = ~address[0];
      2'b10:   w_legal = (address[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  assign w_accept = req && ready;
  assign w_store  = w_accept && we && w_legal;
  assign w_load   = w_accept && !we && w_legal;
  assign w_reject = w_accept && !w_legal;

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = wdata;
    case (size)
      2'b00: begin
        w_be[address[1:0]] = 1'b1;
        w_wlanes           = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be     = address[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{wdata[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
  end

  assign w_rd_word = r_mem[w_idx];
  assign w_half    = address[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    case (address[1:0])
      2'b00:   w_byte = w_rd_word[7:0];
      2'b01:   w_byte = w_rd_word[15:8];
      2'b10:   w_byte = w_rd_word[23:16];
      default: w_byte = w_rd_word[31:24];
    endcase
  end

  always_comb begin
    case (size)
      2'b00:   w_load_data = unsigned_ld ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_data = unsigned_ld ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_data = w_rd_word;
    endcase
  end

  // Contents survive reset; the clear sweep runs only once reset is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_idx] <= 32'd0;
      end else if (w_store) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wlanes[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rvalid    <= 1'b0;
      r_misalign  <= 1'b0;
      r_rdata     <= 32'd0;
      r_err_count <= '0;
    end else begin
      r_rvalid   <= w_load;
      r_misalign <= w_reject;
      if (w_load) r_rdata <= w_load_data;
      if (w_reject && !(&r_err_count)) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign misalign  = r_misalign;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: load results are queued when issued and checked
// against rdata by a monitor whenever rvalid pulses.
module tb_data_mem_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        ready, busy, rvalid, misalign;
  logic [31:0] rdata;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int mis_seen = 0;
  int rv_seen = 0;
  logic [31:0] exp_q[$];

  data_mem_unit #(.ADDR_BITS(7), .ERR_BITS(8)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .address(address), .wdata(wdata),
    .ready(ready), .busy(busy), .rvalid(rvalid), .rdata(rdata),
    .misalign(misalign), .err_count(err_count)
  );

  always #5 clock = ~clock;

  // Monitor: every rvalid must match the oldest outstanding load expectation.
  always @(negedge clock) begin
    if (rvalid === 1'b1) begin
      rv_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid rdata=%08h expected no rvalid", rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL load_data got=%08h expected=%08h", rdata, e);
        end else begin
          $display("load ok rdata=%08h", rdata);
        end
      end
    end
    if (misalign === 1'b1) begin
      mis_seen++;
      $display("misalign pulse err_count=%0d", err_count);
    end
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Drives one access for one cycle; for legal loads, d is the expected rdata.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input logic legal);
    req = 1'b1; we = w; size = sz; unsigned_ld = u; address = a; wdata = d;
    if (!w && legal) exp_q.push_back(d);
    $display("issue we=%0d size=%0d uns=%0d addr=%08h data=%08h", w, sz, u, a, d);
    sync();
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic count_busy(output int n, output int rdy_bad);
    n = 0; rdy_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (busy !== 1'b1) break;
      n++;
      if (ready !== 1'b0) rdy_bad++;
    end
  endtask

  task automatic check_clear(input string tag);
    int n, bad;
    count_busy(n, bad);
    checks++;
    if (n != 128) begin errors++; $display("FAIL %s_busy_cycles got=%0d expected=128", tag, n); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_ready_in_clear got=%0d expected=0", tag, bad); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL %s_ready_after got=%b expected=1", tag, ready); end
    $display("%s clear busy_cycles=%0d", tag, n);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sync(); sync();
    checks++;
    if ({ready, busy, rvalid, misalign} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_flags got=%b expected=0100", {ready, busy, rvalid, misalign});
    end
    checks++;
    if (rdata !== 32'd0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs got=%08h/%0d expected=0/0", rdata, err_count);
    end
    reset = 1'b1;
    check_clear("reset");
    sync();
    issue(0, 2'b10, 0, 32'h14, 32'h0, 1);
    idle();
    drain();
  endtask

  task automatic test_byte();
    issue(1, 2'b10, 0, 32'h10, 32'h11223344, 1);
    issue(1, 2'b00, 0, 32'h12, 32'h000000F0, 1);
    issue(0, 2'b10, 0, 32'h10, 32'h11F03344, 1);
    issue(0, 2'b00, 0, 32'h12, 32'hFFFFFFF0, 1);
    issue(0, 2'b00, 1, 32'h12, 32'h000000F0, 1);
    issue(0, 2'b00, 0, 32'h10, 32'h00000044, 1);
    idle();
    drain();
  endtask

  task automatic test_half();
    issue(1, 2'b10, 0, 32'h20, 32'h12345678, 1);
    issue(1, 2'b01, 0, 32'h22, 32'h00008001, 1);
    issue(0, 2'b01, 0, 32'h22, 32'hFFFF8001, 1);
    issue(0, 2'b01, 1, 32'h20, 32'h00005678, 1);
    issue(0, 2'b10, 0, 32'h20, 32'h80015678, 1);
    idle();
    drain();
  endtask

  task automatic test_misalign();
    int m0, r0;
    m0 = mis_seen; r0 = rv_seen;
    issue(1, 2'b10, 0, 32'h41, 32'hDEADBEEF, 0);
    issue(0, 2'b01, 0, 32'h43, 32'h0, 0);
    issue(0, 2'b11, 0, 32'h40, 32'h0, 0);
    idle();
    @(negedge clock); @(negedge clock);
    checks++;
    if (mis_seen - m0 != 3) begin errors++; $display("FAIL misalign_pulses got=%0d expected=3", mis_seen - m0); end
    checks++;
    if (err_count !== 8'd3) begin errors++; $display("FAIL err_count got=%0d expected=3", err_count); end
    checks++;
    if (rv_seen != r0) begin errors++; $display("FAIL misalign_rvalid got=%0d expected=0", rv_seen - r0); end
    sync();
    issue(0, 2'b10, 0, 32'h40, 32'h0, 1);
    idle();
    drain();
  endtask

  task automatic test_back_to_back();
    issue(1, 2'b10, 0, 32'h200, 32'hA5A5A5A5, 1);
    issue(0, 2'b10, 0, 32'h0, 32'hA5A5A5A5, 1);
    idle();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL b2b_timing got=%b/%08h expected=1/a5a5a5a5", rvalid, rdata);
    end
    drain();
  endtask

  task automatic test_saturate();
    int m0;
    m0 = mis_seen;
    sync();
    for (int i = 0; i < 252; i++) begin
      req = 1'b1; we = 1'b0; size = 2'b11; address = 32'h0;
      sync();
    end
    idle();
    @(negedge clock); @(negedge clock);
    checks++;
    if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_reach got=%0d expected=255", err_count); end
    checks++;
    if (mis_seen - m0 != 252) begin errors++; $display("FAIL sat_pulses got=%0d expected=252", mis_seen - m0); end
    m0 = mis_seen;
    sync();
    issue(1, 2'b01, 0, 32'h1, 32'h0, 0);
    idle();
    @(negedge clock); @(negedge clock);
    checks++;
    if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_hold got=%0d expected=255", err_count); end
    checks++;
    if (mis_seen - m0 != 1) begin errors++; $display("FAIL sat_pulse got=%0d expected=1", mis_seen - m0); end
  endtask

  task automatic test_reset_mid_clear();
    sync();
    req = 1'b1; we = 1'b0; size = 2'b10; address = 32'h0; reset = 1'b0;
    sync();
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_load_rvalid got=%b expected=0", rvalid); end
    idle();
    sync();
    checks++;
    if (err_count !== 8'd0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_clears got=%0d/%08h expected=0/0", err_count, rdata);
    end
    reset = 1'b1;
    for (int i = 0; i < 60; i++) @(negedge clock);
    sync();
    reset = 1'b0;
    sync(); sync();
    reset = 1'b1;
    check_clear("midclear");
    sync();
    issue(0, 2'b10, 0, 32'h0, 32'h0, 1);
    idle();
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_misalign();
    test_back_to_back();
    test_saturate();
    test_reset_mid_clear();
    @(negedge clock); @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
